// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter
//   Shares the single pixel-write port of the 160x120 VGA adapter among NREQ drawing engines.
//   Round-robin arbitration with an exclusive, held grant per burst. A burst that runs past
//   MAX_BURST cycles is preempted when another engine is waiting. The granted engine's
//   x/y/colour/plot are forwarded to the adapter through one register stage.
//
//   Parameters: NREQ (2..4) requesters; MAX_BURST granted cycles before forced rotation
//   (0 disables preemption).
//   Ports:
//     clock, resetn            system clock, synchronous active-low reset
//     req[NREQ]                per-requester port request, held for the whole burst
//     plot_in[NREQ]            per-requester pixel write strobe
//     x_in, y_in, colour_in    packed per-requester pixel data (8/8/3 bits each)
//     gnt[NREQ]                one-hot registered grant, zero when idle
//     vga_x/y/colour/plot      registered pixel write to the adapter
//     busy                     high while any grant is held
//
//   Optional feature: define PLOT_ARB_CLIP_EN to suppress vga_plot for pixels outside
//   160x120 (coordinates still update).
module vga_plot_arbiter #(
   parameter int unsigned NREQ      = 3,
   parameter logic [15:0] MAX_BURST = 16'd19200
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   plot_in,
   input  logic [8*NREQ-1:0] x_in,
   input  logic [8*NREQ-1:0] y_in,
   input  logic [3*NREQ-1:0] colour_in,
   output logic [NREQ-1:0]   gnt,
   output logic [7:0]        vga_x,
   output logic [7:0]        vga_y,
   output logic [2:0]        vga_colour,
   output logic              vga_plot,
   output logic              busy
);

   localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {StIdle, StGrant} state_e;

   state_e        state_q;
   logic [OW-1:0] owner_q;
   logic [OW-1:0] last_q;
   logic [15:0]   cnt_q;

   logic [OW-1:0]   win;
   logic [NREQ-1:0] win_oh;
   logic [NREQ-1:0] owner_oh;
   logic [7:0]      sel_x;
   logic [7:0]      sel_y;
   logic [2:0]      sel_colour;
   logic            pix_ok;
   logic            owner_req;
   logic            preempt;

   // Rotating-priority scan: walk from the farthest candidate back to last+1 so the
   // nearest set request after `last` is the one left in win.
   always_comb begin
      win = '0;
      for (int i = int'(NREQ); i >= 1; i--) begin
         if (req[OW'((int'(last_q) + i) % int'(NREQ))]) begin
            win = OW'((int'(last_q) + i) % int'(NREQ));
         end
      end
   end

   always_comb begin
      sel_x      = '0;
      sel_y      = '0;
      sel_colour = '0;
      win_oh     = '0;
      owner_oh   = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         win_oh[i]   = (win == OW'(i));
         owner_oh[i] = (owner_q == OW'(i));
         if (owner_q == OW'(i)) begin
            sel_x      = x_in[8*i +: 8];
            sel_y      = y_in[8*i +: 8];
            sel_colour = colour_in[3*i +: 3];
         end
      end
   end

   always_comb begin
      owner_req = |(req & owner_oh);
      preempt   = (MAX_BURST != 16'd0) && (cnt_q >= MAX_BURST - 16'd1)
                  && (|(req & ~owner_oh));
`ifdef PLOT_ARB_CLIP_EN
      pix_ok = (sel_x < 8'd160) && (sel_y < 8'd120);
`else
      pix_ok = 1'b1;
`endif
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q    <= StIdle;
         owner_q    <= '0;
         last_q     <= OW'(NREQ - 1);
         cnt_q      <= '0;
         gnt        <= '0;
         busy       <= 1'b0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         vga_plot   <= 1'b0;
      end else begin
         if (|gnt) begin
            vga_x      <= sel_x;
            vga_y      <= sel_y;
            vga_colour <= sel_colour;
         end
         vga_plot <= (|(plot_in & gnt & req & owner_oh)) & pix_ok;

         case (state_q)
            StIdle: begin
               gnt  <= '0;
               busy <= 1'b0;
               if (|req) begin
                  gnt     <= win_oh;
                  busy    <= 1'b1;
                  owner_q <= win;
                  last_q  <= win;
                  cnt_q   <= '0;
                  state_q <= StGrant;
               end
            end
            StGrant: begin
               if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
               // Releasing through IDLE guarantees a one-cycle gap between grants.
               if (!owner_req || preempt) begin
                  gnt     <= '0;
                  busy    <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
